// File: rtl/ca_pkg.sv
// Shared FSM state type and default sizing for the CA-based MAC controller.
package ca_pkg;

  localparam int CA_W_DEF     = 8;
  localparam int CA_STEPS_DEF = 4;
  localparam int CA_LENW_DEF  = 16;
  localparam int CA_CNTW      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ca_state_e;

endpackage

// File: rtl/ca_mac_ctrl.sv
// Sequencer turning an external cellular automaton into a byte-stream MAC engine.
// Optional feature: CA_MAC_PRESET_EN adds an iv port that keys the first byte of each message.
module ca_mac_ctrl
  import ca_pkg::*;
#(
  parameter int W     = CA_W_DEF,
  parameter int STEPS = CA_STEPS_DEF,
  parameter int LENW  = CA_LENW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [0:W-1]    in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:W-1]    out_tag,
  output logic [LENW-1:0] out_len,
  output logic            ca_load,
  output logic            ca_step,
  output logic [0:W-1]    ca_din,
  input  logic [0:W-1]    ca_dout
`ifdef CA_MAC_PRESET_EN
  ,
  input  logic [0:W-1]    iv
`endif
);

  localparam logic [CA_CNTW-1:0] STEP_INIT = CA_CNTW'(STEPS - 1);

  ca_state_e            state_q, state_d;
  logic [0:W-1]         byte_q, byte_d;
  logic                 last_q, last_d;
  logic                 first_q, first_d;
  logic [LENW-1:0]      len_q, len_d;
  logic [CA_CNTW-1:0]   step_cnt_q, step_cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ca_load_q, ca_load_d;
  logic                 ca_step_q, ca_step_d;
  logic [LENW-1:0]      out_len_q, out_len_d;
  logic [0:W-1]         iv_base;
  logic [0:W-1]         load_base;

`ifdef CA_MAC_PRESET_EN
  assign iv_base = iv;
`else
  assign iv_base = '0;
`endif

  // The CA only changes under load/step, so ca_dout is the chaining value during LOAD.
  assign load_base = first_q ? iv_base : ca_dout;

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    last_d     = last_q;
    first_d    = first_q;
    len_d      = len_q;
    step_cnt_d = step_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          byte_d  = in_data;
          last_d  = in_last;
          len_d   = len_q + 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        first_d    = 1'b0;
        step_cnt_d = STEP_INIT;
        state_d    = RUN;
      end
      RUN: begin
        if (step_cnt_q == '0) begin
          state_d = last_q ? DONE : IDLE;
        end else begin
          step_cnt_d = step_cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          first_d = 1'b1;
          len_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Strobes are registered as a decode of the next state so they align with state_q.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    ca_load_d   = (state_d == LOAD);
    ca_step_d   = (state_d == RUN);
    out_valid_d = (state_d == DONE);
    out_len_d   = (state_d == DONE) ? len_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      last_q      <= 1'b0;
      first_q     <= 1'b1;
      len_q       <= '0;
      step_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ca_load_q   <= 1'b0;
      ca_step_q   <= 1'b0;
      out_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      first_q     <= first_d;
      len_q       <= len_d;
      step_cnt_q  <= step_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ca_load_q   <= ca_load_d;
      ca_step_q   <= ca_step_d;
      out_len_q   <= out_len_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ca_load   = ca_load_q;
  assign ca_step   = ca_step_q;
  assign out_len   = out_len_q;
  assign ca_din    = ca_load_q ? (load_base ^ byte_q) : '0;
  assign out_tag   = out_valid_q ? ca_dout : '0;

endmodule

// File: tb/tb_ca_mac_ctrl.sv
// Directed bench for ca_mac_ctrl driving a rule-90 null-boundary CA; honours CA_MAC_PRESET_EN.
module tb_ca_mac_ctrl;

  localparam int W     = 8;
  localparam int STEPS = 4;
  localparam int LENW  = 16;

`ifdef CA_MAC_PRESET_EN
  localparam logic [0:W-1] IV_V = 8'h3C;
`else
  localparam logic [0:W-1] IV_V = 8'h00;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [0:W-1]    in_data = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [0:W-1]    out_tag;
  logic [LENW-1:0] out_len;
  logic            ca_load;
  logic            ca_step;
  logic [0:W-1]    ca_din;
  logic [0:W-1]    ca_dout;
  logic [0:W-1]    iv_v;

  int n_checks = 0;
  int n_pass   = 0;

  logic [0:W-1]    exp_st = '0;
  logic            exp_first = 1'b1;
  logic [LENW-1:0] exp_len = '0;

  assign iv_v = IV_V;

  always #5 clk = ~clk;

  ca_mac_ctrl #(.W(W), .STEPS(STEPS), .LENW(LENW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_len   (out_len),
    .ca_load   (ca_load),
    .ca_step   (ca_step),
    .ca_din    (ca_din),
    .ca_dout   (ca_dout)
`ifdef CA_MAC_PRESET_EN
    ,
    .iv        (iv_v)
`endif
  );

  // Stand-in CA: rule 90 with zero boundaries, reset together with the controller.
  logic [0:W-1] ca_q;
  always_ff @(posedge clk) begin
    if (reset)        ca_q <= '0;
    else if (ca_load) ca_q <= ca_din;
    else if (ca_step) ca_q <= (ca_q >> 1) ^ (ca_q << 1);
  end
  assign ca_dout = ca_q;

  function automatic logic [0:W-1] ca_ref(input logic [0:W-1] s, input int n);
    logic [0:W-1] cur;
    logic [0:W-1] nxt;
    cur = s;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < W; i++) begin
        nxt[i] = 1'b0;
        if (i > 0)     nxt[i] = nxt[i] ^ cur[i-1];
        if (i < W - 1) nxt[i] = nxt[i] ^ cur[i+1];
      end
      cur = nxt;
    end
    return cur;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one byte and checks the LOAD / RUN / exit timing against the model.
  task automatic send_byte(input logic [0:W-1] d, input logic l);
    logic [0:W-1] base;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    base = exp_first ? IV_V : exp_st;
    exp_len++;
    check("load_strobe", 32'(ca_load), 32'd1);
    check("load_din", 32'(ca_din), 32'(base ^ d));
    check("load_nostep", 32'(ca_step), 32'd0);
    exp_st = ca_ref(base ^ d, STEPS);
    exp_first = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      tick();
      check("run_step", 32'(ca_step), 32'd1);
      check("run_noload", 32'(ca_load), 32'd0);
      check("run_busy", 32'(in_ready), 32'd0);
    end
    tick();
    check("exit_nostep", 32'(ca_step), 32'd0);
    if (l) begin
      check("done_valid", 32'(out_valid), 32'd1);
      check("done_tag", 32'(out_tag), 32'(exp_st));
      check("done_len", 32'(out_len), 32'(exp_len));
    end else begin
      check("next_ready", 32'(in_ready), 32'd1);
      check("next_novalid", 32'(out_valid), 32'd0);
    end
    $display("byte %02h last=%0d din=%02h state=%02h len=%0d", d, l, base ^ d, exp_st, exp_len);
  endtask

  task automatic recv_tag();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_first = 1'b1;
    exp_len   = '0;
    check("hs_ready", 32'(in_ready), 32'd1);
    check("hs_novalid", 32'(out_valid), 32'd0);
    check("hs_tag0", 32'(out_tag), 32'd0);
    check("hs_len0", 32'(out_len), 32'd0);
    $display("tag handshake done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_load", 32'(ca_load), 32'd0);
      check("rst_step", 32'(ca_step), 32'd0);
      check("rst_din", 32'(ca_din), 32'd0);
      check("rst_tag", 32'(out_tag), 32'd0);
      check("rst_len", 32'(out_len), 32'd0);
      tick();
    end
    $display("reset/idle checked");

    // Single byte message; 0xA5 under rule 90 for 4 steps hand-evolves to 0xFF.
    send_byte(8'hA5, 1'b1);
`ifndef CA_MAC_PRESET_EN
    check("a5_tag_hand", 32'(out_tag), 32'h0000_00FF);
`endif
    recv_tag();

    // Three-byte message with a stalled consumer.
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_tag", 32'(out_tag), 32'(exp_st));
      check("stall_len", 32'(out_len), 32'd3);
    end
    recv_tag();
    send_byte(8'h55, 1'b1);
    recv_tag();

    // First byte equal to the IV cancels it when the preset is enabled.
    send_byte(8'h3C, 1'b0);
    send_byte(8'h3C, 1'b1);
    recv_tag();

    // Reset during the second RUN step.
    in_valid = 1'b1;
    in_data  = 8'h11;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    tick();
    check("mid_step", 32'(ca_step), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_st = '0;
    exp_first = 1'b1;
    exp_len = '0;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_step", 32'(ca_step), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_novalid", 32'(out_valid), 32'd0);
    end
    send_byte(8'h77, 1'b1);
    recv_tag();
    $display("reset abort checked");

    // in_valid held through DONE is ignored until the tag handshake.
    send_byte(8'hC3, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h9A;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_block_ready", 32'(in_ready), 32'd0);
      check("done_block_load", 32'(ca_load), 32'd0);
      check("done_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_first = 1'b1;
    exp_len = '0;
    check("post_hs_ready", 32'(in_ready), 32'd1);
    check("post_hs_noload", 32'(ca_load), 32'd0);
    check("post_hs_novalid", 32'(out_valid), 32'd0);
    send_byte(8'h9A, 1'b1);
    recv_tag();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
